// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// Accepts MULT, MULTU, DIV, DIVU, MTHI and MTLO from the execute stage and
// exposes HI/LO continuously for MFHI/MFLO. Multiplies complete after
// MULT_STAGES cycles; divides run a radix-2 restoring divider on operand
// magnitudes (32 iterations plus one sign-fix cycle). Divide by zero finishes
// in a single cycle with LO = all ones and HI = dividend.
//
// Parameters
//   MULT_STAGES  multiply latency in cycles, legal range 1..4
//
// Ports
//   clk       in   clock
//   reset     in   synchronous active-high reset
//   in_valid  in   decoded instruction presented
//   in_ready  out  unit can accept (state is IDLE)
//   in_op     in   decoded opcode (MIPS funct encoding for the muldiv group)
//   in_a      in   rs value: dividend / multiplicand / MTHI-MTLO data
//   in_b      in   rt value: divisor / multiplier
//   flush     in   abort in-flight operation, suppress same-cycle accept
//   hi        out  architectural HI
//   lo        out  architectural LO
//   busy      out  multi-cycle operation in flight
//   done      out  one-cycle pulse after a MULT/DIV has updated HI/LO
// -----------------------------------------------------------------------------
module muldiv_unit #(
    parameter int MULT_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  in_op,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic        flush,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done
);

    // Opcodes of the muldiv group; any other in_op value is ignored.
    localparam logic [5:0] OP_MTHI  = 6'h11;
    localparam logic [5:0] OP_MTLO  = 6'h13;
    localparam logic [5:0] OP_MULT  = 6'h18;
    localparam logic [5:0] OP_MULTU = 6'h19;
    localparam logic [5:0] OP_DIV   = 6'h1A;
    localparam logic [5:0] OP_DIVU  = 6'h1B;

    localparam logic [4:0] MUL_LOAD = 5'(MULT_STAGES - 1);
    localparam logic [4:0] DIV_LAST = 5'd31;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DZ
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    // Architectural registers and completion pulse.
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_done;

    // Operation context captured at accept.
    logic [4:0]  r_cnt;
    logic [31:0] r_ma;
    logic [31:0] r_mb;
    logic        r_mul_signed;
    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_dvs;
    logic        r_neg_q;
    logic        r_neg_r;
    logic [31:0] r_dz_a;

    // Decode and handshake.
    logic        w_accept;
    logic        w_is_mul;
    logic        w_is_div;
    logic        w_div_signed;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;

    // Completion strobes (already qualified by ~flush).
    logic        w_mul_fin;
    logic        w_fix_fin;
    logic        w_dz_fin;

    // Multiplier and divider datapath.
    logic [63:0] w_mul_a64;
    logic [63:0] w_mul_b64;
    logic [63:0] w_product;
    logic [32:0] w_shift;
    logic        w_sub_ok;
    logic [31:0] w_diff;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;

    // -------------------------------------------------------------------------
    // Decode
    // -------------------------------------------------------------------------
    assign in_ready     = (r_state == S_IDLE);
    assign busy         = (r_state != S_IDLE);
    assign done         = r_done;
    assign hi           = r_hi;
    assign lo           = r_lo;

    assign w_accept     = in_valid & in_ready & ~flush;
    assign w_is_mul     = (in_op == OP_MULT) | (in_op == OP_MULTU);
    assign w_is_div     = (in_op == OP_DIV)  | (in_op == OP_DIVU);
    assign w_div_signed = (in_op == OP_DIV);

    // Magnitudes for the signed divide; 0x80000000 maps onto itself, which is
    // the correct unsigned magnitude of -2^31.
    assign w_abs_a = (w_div_signed && in_a[31]) ? (32'd0 - in_a) : in_a;
    assign w_abs_b = (w_div_signed && in_b[31]) ? (32'd0 - in_b) : in_b;

    assign w_mul_fin = (r_state == S_MUL) && (r_cnt == 5'd0) && !flush;
    assign w_fix_fin = (r_state == S_FIX) && !flush;
    assign w_dz_fin  = (r_state == S_DZ)  && !flush;

    // -------------------------------------------------------------------------
    // Multiplier: extending both operands to 64 bits (sign or zero) and keeping
    // the low 64 bits of the product gives the exact signed or unsigned result.
    // The operands are held stable for MULT_STAGES cycles, which is the
    // multicycle budget of this path.
    // -------------------------------------------------------------------------
    assign w_mul_a64 = {{32{r_mul_signed & r_ma[31]}}, r_ma};
    assign w_mul_b64 = {{32{r_mul_signed & r_mb[31]}}, r_mb};
    assign w_product = w_mul_a64 * w_mul_b64;

    // -------------------------------------------------------------------------
    // Restoring divider step: shift the next dividend bit into the partial
    // remainder and subtract the divisor when it fits. The shifted value can
    // reach 33 bits, but whenever the subtraction is taken the difference is
    // below the divisor, so 32 bits hold it exactly.
    // -------------------------------------------------------------------------
    assign w_shift  = {r_rem, r_quo[31]};
    assign w_sub_ok = w_shift[32] | (w_shift[31:0] >= r_dvs);
    assign w_diff   = w_shift[31:0] - r_dvs;

    assign w_quo_fix = r_neg_q ? (32'd0 - r_quo) : r_quo;
    assign w_rem_fix = r_neg_r ? (32'd0 - r_rem) : r_rem;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    // NOTE: the default at the top keeps every path assigned, so no latch is
    // inferred for w_state_nxt.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_is_mul) begin
                        w_state_nxt = S_MUL;
                    end else if (w_is_div) begin
                        w_state_nxt = (in_b == 32'd0) ? S_DZ : S_DIV;
                    end
                end
            end
            S_MUL: begin
                if (r_cnt == 5'd0) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DIV: begin
                if (r_cnt == DIV_LAST) begin
                    w_state_nxt = S_FIX;
                end
            end
            S_FIX:   w_state_nxt = S_IDLE;
            S_DZ:    w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        // Flush wins over everything; in IDLE the accept is already blocked.
        if (flush) begin
            w_state_nxt = S_IDLE;
        end
    end

    // -------------------------------------------------------------------------
    // Operation context: counter, operands and divider working registers.
    // -------------------------------------------------------------------------
    // NOTE: these registers carry no reset; they are always loaded at accept
    // before any state consumes them, so resetting them would only add fanout.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_cnt        <= w_is_mul ? MUL_LOAD : 5'd0;
            r_ma         <= in_a;
            r_mb         <= in_b;
            r_mul_signed <= (in_op == OP_MULT);
            r_rem        <= 32'd0;
            r_quo        <= w_abs_a;
            r_dvs        <= w_abs_b;
            r_neg_q      <= w_div_signed & (in_a[31] ^ in_b[31]);
            r_neg_r      <= w_div_signed & in_a[31];
            r_dz_a       <= in_a;
        end else begin
            case (r_state)
                S_MUL: begin
                    r_cnt <= r_cnt - 5'd1;
                end
                S_DIV: begin
                    r_cnt <= r_cnt + 5'd1;
                    r_rem <= w_sub_ok ? w_diff : w_shift[31:0];
                    r_quo <= {r_quo[30:0], w_sub_ok};
                end
                default: begin
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // HI/LO and done. MT* writes happen only in IDLE and completions only in
    // busy states, so at most one writer is active per cycle.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi   <= 32'd0;
            r_lo   <= 32'd0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept && (in_op == OP_MTHI)) begin
                r_hi <= in_a;
            end
            if (w_accept && (in_op == OP_MTLO)) begin
                r_lo <= in_a;
            end
            if (w_mul_fin) begin
                r_hi   <= w_product[63:32];
                r_lo   <= w_product[31:0];
                r_done <= 1'b1;
            end
            if (w_fix_fin) begin
                r_hi   <= w_rem_fix;
                r_lo   <= w_quo_fix;
                r_done <= 1'b1;
            end
            if (w_dz_fin) begin
                r_hi   <= r_dz_a;
                r_lo   <= 32'hFFFF_FFFF;
                r_done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//
// Directed-vector bench for muldiv_unit with MULT_STAGES = 2. Expected HI/LO
// values and busy-cycle counts are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

    localparam int MS = 2;

    localparam logic [5:0] OP_ADD   = 6'h20;
    localparam logic [5:0] OP_MTHI  = 6'h11;
    localparam logic [5:0] OP_MTLO  = 6'h13;
    localparam logic [5:0] OP_MULT  = 6'h18;
    localparam logic [5:0] OP_MULTU = 6'h19;
    localparam logic [5:0] OP_DIV   = 6'h1A;
    localparam logic [5:0] OP_DIVU  = 6'h1B;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        flush;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.MULT_STAGES(MS)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_op    (in_op),
        .in_a     (in_a),
        .in_b     (in_b),
        .flush    (flush),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .done     (done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
    endtask

    // Issue one MULT/DIV, count busy cycles, then check result and done pulse.
    task automatic run_op(input string tag, input logic [5:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input int exp_busy,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        int pulses;
        drive(op, a, b);
        tick;
        in_valid = 1'b0;
        n = 0;
        pulses = 0;
        while (busy && n < 100) begin
            if (done) pulses++;
            n++;
            tick;
        end
        check({tag, " busy cycles"}, 64'(n), 64'(exp_busy));
        check({tag, " early done"}, 64'(pulses), 64'd0);
        check({tag, " done"}, 64'(done), 64'd1);
        check({tag, " hi"}, 64'(hi), 64'(exp_hi));
        check({tag, " lo"}, 64'(lo), 64'(exp_lo));
        tick;
        check({tag, " done single"}, 64'(done), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int pulses;

        reset    = 1'b1;
        in_valid = 1'b0;
        in_op    = 6'd0;
        in_a     = 32'd0;
        in_b     = 32'd0;
        flush    = 1'b0;
        repeat (3) tick;
        reset = 1'b0;

        // Reset state
        check("rst hi", 64'(hi), 64'd0);
        check("rst lo", 64'(lo), 64'd0);
        check("rst busy", 64'(busy), 64'd0);
        check("rst ready", 64'(in_ready), 64'd1);
        check("rst done", 64'(done), 64'd0);
        tick;

        // Non-muldiv op is ignored
        drive(OP_ADD, 32'h1234_5678, 32'h1);
        tick;
        in_valid = 1'b0;
        check("add busy", 64'(busy), 64'd0);
        check("add hi", 64'(hi), 64'd0);
        check("add lo", 64'(lo), 64'd0);

        // Multiplies
        run_op("mult -1*2",  OP_MULT,  32'hFFFF_FFFF, 32'd2, MS, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("multu",      OP_MULTU, 32'hFFFF_FFFF, 32'd2, MS, 32'h0000_0001, 32'hFFFF_FFFE);
        run_op("mult -3*5",  OP_MULT,  32'hFFFF_FFFD, 32'd5, MS, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_op("mult min^2", OP_MULT,  32'h8000_0000, 32'h8000_0000, MS, 32'h4000_0000, 32'h0);

        // Divides
        run_op("div -7/2",   OP_DIV,   32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div 7/-2",   OP_DIV,   32'd7, 32'hFFFF_FFFE, 33, 32'd1, 32'hFFFF_FFFD);
        run_op("divu 100/7", OP_DIVU,  32'd100, 32'd7, 33, 32'd2, 32'd14);
        run_op("div ovf",    OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0, 32'h8000_0000);
        run_op("divu big",   OP_DIVU,  32'hFFFF_FFFF, 32'h0001_0000, 33, 32'h0000_FFFF, 32'h0000_FFFF);
        run_op("divu /0",    OP_DIVU,  32'h1234, 32'd0, 1, 32'h1234, 32'hFFFF_FFFF);
        run_op("div /0",     OP_DIV,   32'hFFFF_FFF0, 32'd0, 1, 32'hFFFF_FFF0, 32'hFFFF_FFFF);

        // Flush mid-divide
        drive(OP_MTHI, 32'hAAAA, 32'd0);
        tick;
        in_valid = 1'b0;
        check("mthi busy", 64'(busy), 64'd0);
        check("mthi done", 64'(done), 64'd0);
        check("mthi hi", 64'(hi), 64'hAAAA);
        drive(OP_MTLO, 32'h5555, 32'd0);
        tick;
        in_valid = 1'b0;
        check("mtlo lo", 64'(lo), 64'h5555);
        drive(OP_DIV, 32'd100, 32'd7);
        tick;
        in_valid = 1'b0;
        repeat (9) tick;
        check("flush busy c10", 64'(busy), 64'd1);
        flush = 1'b1;
        tick;
        flush = 1'b0;
        check("flush idle", 64'(in_ready), 64'd1);
        check("flush busy", 64'(busy), 64'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) pulses++;
            tick;
        end
        check("flush no done", 64'(pulses), 64'd0);
        check("flush hi", 64'(hi), 64'hAAAA);
        check("flush lo", 64'(lo), 64'h5555);

        // Valid together with flush in IDLE: nothing accepted
        drive(OP_MTHI, 32'hDEAD, 32'd0);
        flush = 1'b1;
        tick;
        check("flush+mthi hi", 64'(hi), 64'hAAAA);
        drive(OP_DIVU, 32'd9, 32'd3);
        tick;
        in_valid = 1'b0;
        flush = 1'b0;
        check("flush+divu busy", 64'(busy), 64'd0);
        tick;
        check("flush+divu done", 64'(done), 64'd0);
        check("flush+divu lo", 64'(lo), 64'h5555);

        // in_valid held through busy: no second accept until in_ready
        drive(OP_MULT, 32'd3, 32'd5);
        tick;
        in_b = 32'd7;
        check("hold c1 ready", 64'(in_ready), 64'd0);
        check("hold c1 busy", 64'(busy), 64'd1);
        tick;
        check("hold c2 ready", 64'(in_ready), 64'd0);
        tick;
        check("hold c3 done", 64'(done), 64'd1);
        check("hold c3 ready", 64'(in_ready), 64'd1);
        check("hold c3 lo", 64'(lo), 64'd15);
        check("hold c3 hi", 64'(hi), 64'd0);
        in_b = 32'd6;
        tick;
        in_valid = 1'b0;
        check("hold 2nd accept", 64'(busy), 64'd1);
        n = 0;
        while (busy && n < 10) begin
            n++;
            tick;
        end
        check("hold 2nd busy", 64'(n), 64'(MS));
        check("hold 2nd lo", 64'(lo), 64'd18);
        tick;
        check("hold no 3rd", 64'(busy), 64'd0);

        // Back-to-back MTHI then MULT
        drive(OP_MTHI, 32'h1111, 32'd0);
        tick;
        check("b2b mthi hi", 64'(hi), 64'h1111);
        drive(OP_MULT, 32'd2, 32'd3);
        tick;
        in_valid = 1'b0;
        check("b2b mult busy", 64'(busy), 64'd1);
        n = 0;
        while (busy && n < 10) begin
            n++;
            tick;
        end
        check("b2b hi", 64'(hi), 64'd0);
        check("b2b lo", 64'(lo), 64'd6);

        // Reset mid-MULT
        drive(OP_MTHI, 32'h99, 32'd0);
        tick;
        drive(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        tick;
        in_valid = 1'b0;
        check("rstmul busy", 64'(busy), 64'd1);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check("rstmul hi", 64'(hi), 64'd0);
        check("rstmul lo", 64'(lo), 64'd0);
        check("rstmul busy0", 64'(busy), 64'd0);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            if (done) pulses++;
            tick;
        end
        check("rstmul no done", 64'(pulses), 64'd0);
        check("rstmul hi late", 64'(hi), 64'd0);
        check("rstmul lo late", 64'(lo), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle multiply/divide unit that owns the architectural HI/LO registers. It sits in the execute stage and consumes the decoded instruction stream: MULT, MULTU, DIV, DIVU, MTHI and MTLO with their source operand values. It exposes HI/LO continuously for MFHI/MFLO, and holds the pipeline off through a ready/busy handshake while an operation is in flight.

## Interface
- `MULT_STAGES`, default 2: multiply latency in cycles; legal range 1..4.
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `in_valid`  in  1  a decoded instruction is presented
- `in_ready`  out  1  the unit can accept; equals (state == IDLE)
- `in_op`  in  6  decoded_op_t opcode; only MULT, MULTU, DIV, DIVU, MTHI and MTLO have effect
- `in_a`  in  32  src1 value (rs): dividend or multiplicand, or the MTHI/MTLO data
- `in_b`  in  32  src2 value (rt): divisor or multiplier
- `flush`  in  1  exception or ERET redirect; aborts the in-flight operation
- `hi`  out  32  architectural HI
- `lo`  out  32  architectural LO
- `busy`  out  1  a multi-cycle operation is in flight
- `done`  out  1  one-cycle pulse after HI/LO are updated by a MULT or DIV

## Operation
- Accept condition: `accept = in_valid & in_ready & ~flush`.
- Non-muldiv ops in `in_op` are ignored. `in_ready` does not depend on `in_op`.
- States and transitions:
  - IDLE: MULT/MULTU → MUL; DIV/DIVU with `in_b != 0` → DIV; DIV/DIVU with `in_b == 0` → DZ.
  - MTHI/MTLO stay in IDLE and write `hi`/`lo` at the accept edge.
  - MUL: down-counter loaded with MULT_STAGES-1 at accept. When the count is 0 and the state is MUL, HI/LO are written and the state goes to IDLE.
  - DIV: radix-2 restoring divider on magnitudes. Iteration counter 0..31, one quotient bit per cycle.
    - The absolute values of `in_a` and `in_b` are captured at accept for signed ops; unsigned ops capture them raw.
    - The sign of the quotient is `a[31]^b[31]`; the sign of the remainder is `a[31]`.
    - After iteration 31 → FIX.
  - FIX: applies the sign corrections and writes `lo`=quotient and `hi`=remainder; → IDLE.
  - DZ (divide by zero): writes `lo`=32'hFFFFFFFF and `hi`=`in_a` (captured at accept); → IDLE.
- Multiply results:
  - MULT: 64-bit signed product. MULTU: 64-bit unsigned product.
  - `hi`=product[63:32], `lo`=product[31:0].
- Signed overflow: 32'h80000000 / 32'hFFFFFFFF yields `lo`=32'h80000000, `hi`=0. This falls out of the magnitude algorithm; no special case is needed.
- Flush:
  - Any state returns to IDLE at the next edge.
  - HI/LO are not written and `done` is not pulsed.
  - An accept in the same cycle as the flush is suppressed.
- MTHI/MTLO and a completing MULT/DIV can never write HI/LO in the same cycle, because MT* is accepted only in IDLE.
- Reset:
  - State=IDLE; `hi`=`lo`=0; `busy`=0; `done`=0; `in_ready`=1 from the cycle after reset is sampled.
  - Reset mid-operation discards the operation.

## Timing
- Let E0 be the accept edge.
- MULT/MULTU:
  - `busy`=1 for cycles E0+1 .. E0+MULT_STAGES.
  - HI/LO are written at edge E0+MULT_STAGES.
  - `done`=1 and `busy`=0 in the following cycle, and a new op may be accepted in that cycle.
- DIV/DIVU: 32 iteration cycles plus 1 FIX cycle.
  - `busy`=1 for 33 cycles.
  - HI/LO are written at edge E0+33; `done`=1 in the next cycle.
- Divide by zero: `busy`=1 for 1 cycle; HI/LO are written at E0+1; `done` is pulsed after.
- MTHI/MTLO: `busy` stays 0. The new `hi`/`lo` value is visible in the cycle after E0, with no `done`.
- Read path: `hi` and `lo` are register outputs with no bypass. The pipeline stalls MFHI/MFLO while `busy`=1.

## Test plan
- Reset then idle → `hi`=`lo`=0, `busy`=0, `in_ready`=1.
- Multiply, `MULT_STAGES`=2:
  - MULT a=FFFFFFFF, b=2 → `hi`=FFFFFFFF, `lo`=FFFFFFFE written at E0+2.
  - MULTU with the same operands → `hi`=00000001, `lo`=FFFFFFFE.
  - `done` is a single pulse in each case.
- Signed and unsigned divide:
  - DIV a=FFFFFFF9 (−7), b=2 → `lo`=FFFFFFFD, `hi`=FFFFFFFF after exactly 33 busy cycles.
  - DIVU a=100, b=7 → `lo`=14, `hi`=2.
- Divide edge cases:
  - DIV 80000000 / FFFFFFFF → `lo`=80000000, `hi`=0.
  - DIVU a=1234, b=0 → `lo`=FFFFFFFF, `hi`=1234 after 1 busy cycle.
- Flush mid-divide: preload MTHI 0xAAAA and MTLO 0x5555, start DIV, assert `flush` on busy cycle 10 → next cycle IDLE, `hi`/`lo` remain 0xAAAA/0x5555, no `done`.
- Handshake and simultaneous events:
  - `in_valid` held during `busy` → no second accept until `in_ready`.
  - `in_valid` and `flush` in the same IDLE cycle → nothing accepted.
  - Back-to-back MTHI then MULT → MULT overwrites HI.
  - `reset` asserted mid-MULT → `hi`/`lo`=0 and nothing is written later.
